// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types and constants for the stage registers
// between the core's pipe stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    // Default field widths; used for the reference lane layout below.
    localparam int PKG_ADDR_W = 5;
    localparam int PKG_DATA_W = 32;

    // Write-back result source select
    localparam logic LW_ALU_SRC = 1'b0;
    localparam logic LW_MEM_SRC = 1'b1;

    localparam logic [PKG_DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic [PKG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

    // Reference layout of one write-back lane, MSB first. Stages built with
    // non-default widths keep the same field order (see lane_bits()).
    typedef struct packed {
        logic                  lwsrc;
        logic [PKG_ADDR_W-1:0] write_addr;
        logic                  reg_write;
        logic [PKG_DATA_W-1:0] movsrc_result;
        logic [PKG_DATA_W-1:0] dm_out;
    } wb_lane_t;

    // Occupancy of a two-entry stage buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Width of one lane with the wb_lane_t field order at arbitrary widths
    function automatic int lane_bits(input int addr_w, input int data_w);
        return 2 + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready buffer. in_ready is decoded from the state
// register only, so upstream never sees a combinational path from out_ready.
// clear drops both entries without touching the stored data.
module skid_buf_2
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    stage_state_e state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         accept, drain;
    logic         load_main_in, load_main_skid, load_skid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state decode; clear wins over any accept/drain
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = BUSY;
                BUSY: begin
                    if (accept && !drain)      state_nxt = FULL;
                    else if (!accept && drain) state_nxt = EMPTY;
                end
                FULL:  if (drain) state_nxt = BUSY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake and entry-load decode from the registered state
    always_comb begin
        in_ready       = (state != FULL);
        out_valid      = (state != EMPTY);
        accept         = in_valid & in_ready;
        drain          = out_valid & out_ready;
        load_main_in   = !clear && accept &&
                         ((state == EMPTY) || ((state == BUSY) && drain));
        load_skid      = !clear && accept && (state == BUSY) && !drain;
        load_main_skid = !clear && (state == FULL) && drain;
    end

    // Entry storage; data is only ever cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline boundary carrying LANES write-back lanes per packet through
// a 2-entry skid buffer. Adds flush, bubble gating of reg_write and a
// saturating back-pressure cycle counter on top of the generic buffer.
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         mem_lwsrc,
    input  logic [LANES*ADDR_W-1:0]  mem_write_addr,
    input  logic [LANES-1:0]         mem_reg_write,
    input  logic [LANES*DATA_W-1:0]  mem_movsrc_result,
    input  logic [LANES*DATA_W-1:0]  mem_dm_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         wb_lwsrc,
    output logic [LANES*ADDR_W-1:0]  wb_write_addr,
    output logic [LANES-1:0]         wb_reg_write,
    output logic [LANES*DATA_W-1:0]  wb_movsrc_result,
    output logic [LANES*DATA_W-1:0]  wb_dm_out,
    output logic [CNT_W-1:0]         bp_cnt
);

    localparam int LANE_W = lane_bits(ADDR_W, DATA_W);
    localparam int PAY_W  = LANES * LANE_W;

    logic [PAY_W-1:0] in_pay, out_pay;
    logic [LANES-1:0] main_reg_write;

    // Lane packing in wb_lane_t field order; lane 0 in the low bits
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_pay[i*LANE_W +: LANE_W] = {
            mem_lwsrc[i],
            mem_write_addr[i*ADDR_W +: ADDR_W],
            mem_reg_write[i],
            mem_movsrc_result[i*DATA_W +: DATA_W],
            mem_dm_out[i*DATA_W +: DATA_W]
        };
        assign {
            wb_lwsrc[i],
            wb_write_addr[i*ADDR_W +: ADDR_W],
            main_reg_write[i],
            wb_movsrc_result[i*DATA_W +: DATA_W],
            wb_dm_out[i*DATA_W +: DATA_W]
        } = out_pay[i*LANE_W +: LANE_W];
    end

    skid_buf_2 #(
        .W(PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    // Bubbles (empty stage, including right after a flush) never write the RF
    assign wb_reg_write = main_reg_write & {LANES{out_valid}};

    // Count stalled-output cycles, sticking at all-ones; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bp_cnt <= '0;
        else if (out_valid && !out_ready && (bp_cnt != {CNT_W{1'b1}}))
            bp_cnt <= bp_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage with LANES=2 and a 4-bit counter.
module tb_mem_wb_skid_stage;

    localparam int LANES = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES-1:0]    mem_lwsrc = '0;
    logic [LANES*AW-1:0] mem_write_addr = '0;
    logic [LANES-1:0]    mem_reg_write = '0;
    logic [LANES*DW-1:0] mem_movsrc_result = '0;
    logic [LANES*DW-1:0] mem_dm_out = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LANES-1:0]    wb_lwsrc;
    logic [LANES*AW-1:0] wb_write_addr;
    logic [LANES-1:0]    wb_reg_write;
    logic [LANES*DW-1:0] wb_movsrc_result;
    logic [LANES*DW-1:0] wb_dm_out;
    logic [CW-1:0]       bp_cnt;

    int checks = 0;
    int errors = 0;

    mem_wb_skid_stage #(
        .DATA_W(DW), .ADDR_W(AW), .LANES(LANES), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_lwsrc(mem_lwsrc), .mem_write_addr(mem_write_addr),
        .mem_reg_write(mem_reg_write), .mem_movsrc_result(mem_movsrc_result),
        .mem_dm_out(mem_dm_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_lwsrc(wb_lwsrc), .wb_write_addr(wb_write_addr),
        .wb_reg_write(wb_reg_write), .wb_movsrc_result(wb_movsrc_result),
        .wb_dm_out(wb_dm_out), .bp_cnt(bp_cnt)
    );

    always #5 clk = ~clk;

    // Packet id -> per-lane field encoding (lane 0 low bits)
    function automatic logic [LANES*AW-1:0] e_addr(input logic [7:0] id);
        return {id[4:0] ^ 5'h10, id[4:0]};
    endfunction
    function automatic logic [LANES*DW-1:0] e_mov(input logic [7:0] id);
        logic [31:0] b;
        b = {20'h0, id, 4'h0};
        return {b + 32'd1, b};
    endfunction
    function automatic logic [LANES*DW-1:0] e_dm(input logic [7:0] id);
        return {32'hE000_0000 | {24'h0, id}, 32'hD000_0000 | {24'h0, id}};
    endfunction
    function automatic logic [LANES-1:0] e_lw(input logic [7:0] id);
        return {~id[0], id[0]};
    endfunction
    function automatic logic [LANES-1:0] e_rw(input logic [7:0] id);
        return {id[1], 1'b1};
    endfunction

    task automatic send(input logic v, input logic [7:0] id);
        in_valid          = v;
        mem_write_addr    = e_addr(id);
        mem_movsrc_result = e_mov(id);
        mem_dm_out        = e_dm(id);
        mem_lwsrc         = e_lw(id);
        mem_reg_write     = e_rw(id);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bp_cnt !== '0) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b bp_cnt=%0d, want 0 1 0",
                     out_valid, in_ready, bp_cnt);
        end
        checks++;
        if (wb_lwsrc !== '0 || wb_write_addr !== '0 || wb_reg_write !== '0 ||
            wb_movsrc_result !== '0 || wb_dm_out !== '0) begin
            errors++;
            $display("FAIL reset_wb: lw=%b addr=%h rw=%b mov=%h dm=%h, want all 0",
                     wb_lwsrc, wb_write_addr, wb_reg_write, wb_movsrc_result, wb_dm_out);
        end
        @(negedge clk) rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_reg_write !== '0 || bp_cnt !== '0) begin
            errors++;
            $display("FAIL idle: out_valid=%b in_ready=%b rw=%b bp=%0d, want 0 1 0 0",
                     out_valid, in_ready, wb_reg_write, bp_cnt);
        end
    endtask

    task automatic test_stream;
        logic [7:0] id;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) send(1'b1, 8'(k + 1));
            else       send(1'b0, 8'd0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready%0d: in_ready=%b want 1", k, in_ready);
            end
            if (k > 0) begin
                id = 8'(k);
                checks++;
                if (out_valid !== 1'b1 || wb_write_addr !== e_addr(id) ||
                    wb_movsrc_result !== e_mov(id) || wb_dm_out !== e_dm(id) ||
                    wb_lwsrc !== e_lw(id) || wb_reg_write !== e_rw(id)) begin
                    errors++;
                    $display("FAIL stream_pkt%0d: v=%b addr=%h mov=%h rw=%b, want v=1 addr=%h mov=%h rw=%b",
                             k, out_valid, wb_write_addr, wb_movsrc_result, wb_reg_write,
                             e_addr(id), e_mov(id), e_rw(id));
                end
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || wb_reg_write !== '0 || wb_write_addr !== e_addr(8'd4) ||
            wb_movsrc_result !== e_mov(8'd4)) begin
            errors++;
            $display("FAIL bubble_hold: v=%b rw=%b addr=%h mov=%h, want v=0 rw=0 addr=%h mov=%h",
                     out_valid, wb_reg_write, wb_write_addr, wb_movsrc_result,
                     e_addr(8'd4), e_mov(8'd4));
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        send(1'b1, 8'd5);                      // A
        tick();
        out_ready = 1'b0;
        send(1'b1, 8'd6);                      // B
        checks++;
        if (in_ready !== 1'b1 || wb_write_addr !== e_addr(8'd5)) begin
            errors++;
            $display("FAIL bp_busy: in_ready=%b addr=%h, want 1 %h", in_ready, wb_write_addr, e_addr(8'd5));
        end
        tick();
        send(1'b1, 8'd7);                      // C, held upstream
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || wb_write_addr !== e_addr(8'd5) ||
                bp_cnt !== CW'(j + 1)) begin
                errors++;
                $display("FAIL bp_stall%0d: in_ready=%b v=%b addr=%h bp=%0d, want 0 1 %h %0d",
                         j, in_ready, out_valid, wb_write_addr, bp_cnt, e_addr(8'd5), j + 1);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || wb_movsrc_result !== e_mov(8'd5) || bp_cnt !== 4'd4) begin
            errors++;
            $display("FAIL bp_relA: in_ready=%b mov=%h bp=%0d, want 0 %h 4",
                     in_ready, wb_movsrc_result, bp_cnt, e_mov(8'd5));
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || wb_movsrc_result !== e_mov(8'd6) ||
            wb_dm_out !== e_dm(8'd6)) begin
            errors++;
            $display("FAIL bp_relB: in_ready=%b v=%b mov=%h, want 1 1 %h",
                     in_ready, out_valid, wb_movsrc_result, e_mov(8'd6));
        end
        tick();
        send(1'b0, 8'd0);
        checks++;
        if (out_valid !== 1'b1 || wb_movsrc_result !== e_mov(8'd7) || wb_reg_write !== e_rw(8'd7)) begin
            errors++;
            $display("FAIL bp_relC: v=%b mov=%h rw=%b, want 1 %h %b",
                     out_valid, wb_movsrc_result, wb_reg_write, e_mov(8'd7), e_rw(8'd7));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || bp_cnt !== 4'd4) begin
            errors++;
            $display("FAIL bp_done: v=%b bp=%0d, want 0 4", out_valid, bp_cnt);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        send(1'b1, 8'd9);
        tick();
        send(1'b1, 8'd10);
        tick();
        send(1'b1, 8'd11);
        flush = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: in_ready=%b want 0", in_ready);
        end
        tick();
        flush = 1'b0;
        send(1'b0, 8'd0);
        checks++;
        if (out_valid !== 1'b0 || wb_reg_write !== '0 || in_ready !== 1'b1 ||
            wb_write_addr !== e_addr(8'd9) || bp_cnt !== 4'd6) begin
            errors++;
            $display("FAIL flush_full_after: v=%b rw=%b in_ready=%b addr=%h bp=%0d, want 0 0 1 %h 6",
                     out_valid, wb_reg_write, in_ready, wb_write_addr, bp_cnt, e_addr(8'd9));
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_drop: out_valid=%b want 0", out_valid);
        end
        send(1'b1, 8'd12);
        tick();
        send(1'b1, 8'd13);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(1'b0, 8'd0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_reg_write !== '0 ||
            wb_write_addr !== e_addr(8'd12) || bp_cnt !== 4'd6) begin
            errors++;
            $display("FAIL flush_busy: v=%b in_ready=%b rw=%b addr=%h bp=%0d, want 0 1 0 %h 6",
                     out_valid, in_ready, wb_reg_write, wb_write_addr, bp_cnt, e_addr(8'd12));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_drop: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        send(1'b1, 8'd14);
        tick();
        send(1'b1, 8'd15);
        tick();
        send(1'b0, 8'd0);
        checks++;
        if (bp_cnt !== 4'd7 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_pre: bp=%0d in_ready=%b, want 7 0", bp_cnt, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bp_cnt !== '0 || wb_reg_write !== '0 ||
            wb_write_addr !== '0 || wb_movsrc_result !== '0 || wb_dm_out !== '0 || wb_lwsrc !== '0) begin
            errors++;
            $display("FAIL arst_now: v=%b in_ready=%b bp=%0d addr=%h mov=%h dm=%h lw=%b, want 0 1 0 and zeros",
                     out_valid, in_ready, bp_cnt, wb_write_addr, wb_movsrc_result, wb_dm_out, wb_lwsrc);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bp_cnt !== '0) begin
            errors++;
            $display("FAIL arst_after: v=%b in_ready=%b bp=%0d, want 0 1 0", out_valid, in_ready, bp_cnt);
        end
    endtask

    task automatic test_saturation;
        int exp;
        out_ready = 1'b0;
        send(1'b1, 8'd16);
        tick();
        send(1'b0, 8'd0);
        for (int j = 0; j < 20; j++) begin
            tick();
            exp = (j + 1 > 15) ? 15 : j + 1;
            checks++;
            if (bp_cnt !== CW'(exp)) begin
                errors++;
                $display("FAIL sat%0d: bp_cnt=%0d want %0d", j, bp_cnt, exp);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || bp_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_drain: v=%b bp=%0d, want 0 15", out_valid, bp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
